// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial a - b, LSB first, with one borrow flop and a start/done handshake
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sr, sr_nxt;
    logic [CW-1:0] cnt;
    logic bor, bor_nxt, d, last;
    assign d       = sa[0] ^ sb[0] ^ bor;
    assign bor_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);
    assign sr_nxt  = {d, sr[WIDTH-1:1]};
    assign last    = cnt == CW'(WIDTH - 1);
    assign busy    = state == RUN;
    assign done    = state == DONE;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    // sr collects result bits privately; diff only updates on the final bit
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (state == IDLE && start) begin
            sa  <= a;
            sb  <= b;
            bor <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_nxt;
            bor <= bor_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                diff       <= sr_nxt;
                borrow_out <= bor_nxt;
            end
        end
endmodule
